// File: rtl/mem_ctrl_arbiter.sv
// Byte-wide RAM port arbiter between the IF fetch stream and MEM-stage loads/stores.
// MEM accesses are split into little-endian byte beats; IF is served only while the port is idle.
module mem_ctrl_arbiter #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_request_i,
  input  logic [31:0]           if_addr_i,
  input  logic [1:0]            mem_request_i,
  input  logic [1:0]            mem_width_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_busy_o,
  output logic [7:0]            mem_ctrl_data_o,
  output logic [1:0]            if_or_mem_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_TAIL, MEM_WR, DONE} state_e;

  state_e                  state_q, state_d;
  logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              last_q, last_d;
  logic                    ifPending_q, ifPending_d;
  logic                    memReq;
  logic [1:0]              rdIdx;
  logic                    unusedAddrBits;

  // Gated by rst so nothing looks requested while reset is held.
  assign memReq = rst & ((mem_request_i == 2'b01) | (mem_request_i == 2'b10));
  assign rdIdx  = cnt_q - 2'd1;
  assign unusedAddrBits = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  assign mem_ctrl_data_o = ram_din_i;
  assign mem_rdata_o     = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      ifPending_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ifPending_q <= ifPending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ifPending_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (memReq) begin
          addr_d  = mem_addr_i[RAM_ADDR_W-1:0];
          wdata_d = mem_wdata_i;
          rdata_d = '0;
          cnt_d   = '0;
          case (mem_width_i)
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
          endcase
          state_d = (mem_request_i == 2'b01) ? MEM_RD : MEM_WR;
        end else if (if_request_i) begin
          ifPending_d = 1'b1;
        end
      end
      MEM_RD: begin
        // The byte arriving now belongs to the previous beat; cnt wraps so TAIL lands on last_q.
        if (cnt_q != 2'd0) rdata_d[{rdIdx, 3'b000} +: 8] = ram_din_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) state_d = MEM_TAIL;
      end
      MEM_TAIL: begin
        rdata_d[{rdIdx, 3'b000} +: 8] = ram_din_i;
        state_d = DONE;
      end
      MEM_WR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wr_o    = 1'b0;
    ram_dout_o  = '0;
    mem_done_o  = 1'b0;
    mem_busy_o  = 1'b1;
    if_or_mem_o = 2'b00;
    case (state_q)
      IDLE: begin
        mem_busy_o = memReq;
        if (rst && !memReq && if_request_i) ram_addr_o = if_addr_i[RAM_ADDR_W-1:0];
        if (ifPending_q) if_or_mem_o = 2'b01;
      end
      MEM_RD: begin
        ram_addr_o = addr_q + RAM_ADDR_W'(cnt_q);
        if (cnt_q != 2'd0) if_or_mem_o = 2'b10;
      end
      MEM_TAIL: if_or_mem_o = 2'b10;
      MEM_WR: begin
        ram_addr_o = addr_q + RAM_ADDR_W'(cnt_q);
        ram_wr_o   = 1'b1;
        ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
      end
      DONE:    mem_done_o = 1'b1;
      default: mem_busy_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Self-checking bench for mem_ctrl_arbiter with a behavioural byte RAM
// and a tagged-byte scoreboard for the IF/MEM return stream.
module tb_mem_ctrl_arbiter;

  localparam int RAM_ADDR_W = 17;
  localparam logic [31:0] ADDR_MASK = 32'h0001_FFFF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  if_request_i;
  logic [31:0]           if_addr_i;
  logic [1:0]            mem_request_i;
  logic [1:0]            mem_width_i;
  logic [31:0]           mem_addr_i;
  logic [31:0]           mem_wdata_i;
  logic [31:0]           mem_rdata_o;
  logic                  mem_done_o;
  logic                  mem_busy_o;
  logic [7:0]            mem_ctrl_data_o;
  logic [1:0]            if_or_mem_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i = 8'h00;

  logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
  logic [9:0] sbQueue [$];
  int checkCount = 0;
  int errorCount = 0;

  mem_ctrl_arbiter #(.RAM_ADDR_W(RAM_ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_request_i(if_request_i), .if_addr_i(if_addr_i),
    .mem_request_i(mem_request_i), .mem_width_i(mem_width_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_busy_o(mem_busy_o),
    .mem_ctrl_data_o(mem_ctrl_data_o), .if_or_mem_o(if_or_mem_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: one-cycle read latency, write at the clock edge.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Every tagged return byte is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (rst && if_or_mem_o != 2'b00) begin
      if (sbQueue.size() == 0) checkOutput("sb_unexpected", {54'd0, if_or_mem_o, mem_ctrl_data_o}, 64'd0);
      else checkOutput("sb_tagdata", {54'd0, if_or_mem_o, mem_ctrl_data_o}, {54'd0, sbQueue.pop_front()});
    end
  end

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic [1:0] memReq, input logic [1:0] width,
                               input logic [31:0] memAddr, input logic [31:0] wdata);
    if_request_i  = ifReq;
    if_addr_i     = ifAddr;
    mem_request_i = memReq;
    mem_width_i   = width;
    mem_addr_i    = memAddr;
    mem_wdata_i   = wdata;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  // Runs one MEM access from the request cycle to the first IDLE cycle after DONE,
  // checking cycle-accurate address/write/tag/done/busy behaviour.
  task automatic memAccess(input logic isLoad, input logic [1:0] width, input logic [31:0] addr,
                           input logic [31:0] data, input logic ifReq, input logic [31:0] ifAddr,
                           input logic [7:0] ifByte);
    int n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    int doneCyc = isLoad ? n + 2 : n + 1;
    if (isLoad) for (int i = 0; i < n; i++) sbQueue.push_back({2'b10, data[8*i +: 8]});
    applyStimulus(ifReq, ifAddr, isLoad ? 2'b01 : 2'b10, width, addr, isLoad ? 32'hFFFF_FFFF : data);
    for (int c = 0; c <= doneCyc; c++) begin
      @(negedge clk);
      checkOutput("busy", {63'd0, mem_busy_o}, 64'd1);
      checkOutput("done", {63'd0, mem_done_o}, {63'd0, (c == doneCyc)});
      checkOutput("tag", {62'd0, if_or_mem_o}, (isLoad && c >= 2 && c <= n + 1) ? 64'd2 : 64'd0);
      if (c >= 1 && c <= n) begin
        checkOutput("ram_addr", {47'd0, ram_addr_o}, {32'd0, (addr + 32'(c - 1)) & ADDR_MASK});
        checkOutput("ram_wr", {63'd0, ram_wr_o}, isLoad ? 64'd0 : 64'd1);
        if (!isLoad) checkOutput("ram_dout", {56'd0, ram_dout_o}, {56'd0, data[8*(c-1) +: 8]});
      end else begin
        checkOutput("ram_wr_idle", {63'd0, ram_wr_o}, 64'd0);
      end
      if (isLoad && c == doneCyc) checkOutput("rdata", {32'd0, mem_rdata_o}, {32'd0, data});
      @(posedge clk); #1;
      if (c == 0) begin
        mem_width_i = ~width;
        mem_addr_i  = addr + 32'h40;
        mem_wdata_i = ~data;
      end
    end
    mem_request_i = 2'b00;
    if (ifReq) sbQueue.push_back({2'b01, ifByte});
    @(negedge clk);
    checkOutput("busy_after_done", {63'd0, mem_busy_o}, 64'd0);
    @(posedge clk); #1;
    if_request_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << RAM_ADDR_W); i++) ram[i] = 8'h00;
    ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'hA0; ram[3] = 8'hE3;
    ram['h1000] = 8'h78; ram['h1001] = 8'h56; ram['h1002] = 8'h34; ram['h1003] = 8'h12;
    ram['h2000] = 8'h11; ram['h2001] = 8'h22; ram['h2002] = 8'h33; ram['h2003] = 8'h44;
    ram['h1FFFF] = 8'hAA;

    // Reset with requests pending: everything must stay quiet.
    rst = 1'b0;
    applyStimulus(1'b1, 32'd5, 2'b01, 2'b10, 32'h1000, 32'd0);
    #12;
    checkOutput("rst_ram_addr", {47'd0, ram_addr_o}, 64'd0);
    checkOutput("rst_busy", {63'd0, mem_busy_o}, 64'd0);
    checkOutput("rst_tag", {62'd0, if_or_mem_o}, 64'd0);
    checkOutput("rst_done", {63'd0, mem_done_o}, 64'd0);
    checkOutput("rst_rdata", {32'd0, mem_rdata_o}, 64'd0);
    checkOutput("rst_wr", {63'd0, ram_wr_o}, 64'd0);
    applyStimulus(1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idleCycle();

    $display("[TB] IF byte stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i), 2'b00, 2'b00, 32'd0, 32'd0);
      sbQueue.push_back({2'b01, ram[i]});
      @(negedge clk);
      checkOutput("if_addr", {47'd0, ram_addr_o}, 64'(i));
      checkOutput("if_busy", {63'd0, mem_busy_o}, 64'd0);
      checkOutput("if_tag", {62'd0, if_or_mem_o}, (i == 0) ? 64'd0 : 64'd1);
      @(posedge clk); #1;
    end
    idleCycle();

    $display("[TB] word, half, byte and width-11 loads");
    memAccess(1'b1, 2'b10, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'd0, 8'h00);
    idleCycle();
    memAccess(1'b1, 2'b01, 32'h0000_1002, 32'h0000_1234, 1'b0, 32'd0, 8'h00);
    idleCycle();
    memAccess(1'b1, 2'b11, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'd0, 8'h00);
    idleCycle();

    $display("[TB] half store");
    memAccess(1'b0, 2'b01, 32'h0000_2001, 32'h0000_BEEF, 1'b0, 32'd0, 8'h00);
    idleCycle();
    checkOutput("st_2000", {56'd0, ram['h2000]}, 64'h11);
    checkOutput("st_2001", {56'd0, ram['h2001]}, 64'hEF);
    checkOutput("st_2002", {56'd0, ram['h2002]}, 64'hBE);
    checkOutput("st_2003", {56'd0, ram['h2003]}, 64'h44);

    $display("[TB] IF and MEM collide");
    memAccess(1'b1, 2'b00, 32'h0000_1001, 32'h0000_0056, 1'b1, 32'd2, 8'hA0);
    @(negedge clk);
    checkOutput("if_after_mem_tag", {62'd0, if_or_mem_o}, 64'd1);
    @(posedge clk); #1;
    idleCycle();

    $display("[TB] wrapping word load");
    memAccess(1'b1, 2'b10, 32'hFFF1_FFFF, 32'hA000_13AA, 1'b0, 32'd0, 8'h00);
    idleCycle();

    $display("[TB] reset during word store");
    applyStimulus(1'b0, 32'd0, 2'b10, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_rst_wr", {63'd0, ram_wr_o}, 64'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_wr", {63'd0, ram_wr_o}, 64'd0);
    checkOutput("async_addr", {47'd0, ram_addr_o}, 64'd0);
    checkOutput("async_dout", {56'd0, ram_dout_o}, 64'd0);
    checkOutput("async_busy", {63'd0, mem_busy_o}, 64'd0);
    checkOutput("async_tag", {62'd0, if_or_mem_o}, 64'd0);
    checkOutput("async_done", {63'd0, mem_done_o}, 64'd0);
    mem_request_i = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("rst_st_3000", {56'd0, ram['h3000]}, 64'hEF);
    checkOutput("rst_st_3001", {56'd0, ram['h3001]}, 64'hBE);
    checkOutput("rst_st_3002", {56'd0, ram['h3002]}, 64'h00);
    checkOutput("rst_st_3003", {56'd0, ram['h3003]}, 64'h00);

    checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
